// File: rtl/decode_queue_pkg.sv
// Shared decode constants: instruction classes, MIPS opcode/func fields,
// destination-register source encoding and the queue entry layout.
package decode_queue_pkg;

  typedef enum logic [3:0] {
    CLS_ALU_R    = 4'd0,
    CLS_ALU_I    = 4'd1,
    CLS_LOAD     = 4'd2,
    CLS_STORE    = 4'd3,
    CLS_BRANCH   = 4'd4,
    CLS_JUMP     = 4'd5,
    CLS_MD_START = 4'd6,
    CLS_MD_MOVE  = 4'd7,
    CLS_CP0      = 4'd8,
    CLS_TRAP     = 4'd9,
    CLS_NOP      = 4'd10,
    CLS_UNDEF    = 4'd15
  } cls_e;

  typedef enum logic [1:0] {
    A3_ZERO,
    A3_RT,
    A3_RD,
    A3_RA
  } a3_src_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_DIVU    = 6'h1B;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_SLTU    = 6'h2B;
  localparam logic [5:0] F_ERET    = 6'h18;

  localparam logic [4:0] RS_MF  = 5'h00;
  localparam logic [4:0] RS_MT  = 5'h04;
  localparam logic [4:0] RS_CO  = 5'h10;

  typedef struct packed {
    logic [31:0] pc;
    cls_e        cls;
    logic [4:0]  a3;
    logic        regwrite;
    logic [31:0] instr;
  } dq_entry_t;

endpackage

// File: rtl/decode_queue_classify.sv
// Combinational MIPS-I classifier: instruction class, destination
// register and register-file write enable for one instruction word.
module instr_classify
  import decode_queue_pkg::*;
(
  input  logic [31:0] instr,
  output cls_e        cls,
  output logic [4:0]  a3,
  output logic        regwrite
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [5:0] w_fn;
  logic       w_unused_shamt;
  a3_src_e    w_src;

  assign w_op = instr[31:26];
  assign w_rs = instr[25:21];
  assign w_rt = instr[20:16];
  assign w_rd = instr[15:11];
  assign w_fn = instr[5:0];
  assign w_unused_shamt = ^instr[10:6];

  always_comb begin
    cls   = CLS_UNDEF;
    w_src = A3_ZERO;
    unique case (w_op)
      OP_SPECIAL: begin
        unique case (w_fn)
          F_SLL: begin
            cls   = (w_rd == 5'd0) ? CLS_NOP : CLS_ALU_R;
            w_src = (w_rd == 5'd0) ? A3_ZERO : A3_RD;
          end
          F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, F_SLTU: begin
            cls   = CLS_ALU_R;
            w_src = A3_RD;
          end
          F_JR:   cls = CLS_JUMP;
          F_JALR: begin
            cls   = CLS_JUMP;
            w_src = A3_RD;
          end
          F_SYSCALL, F_BREAK: cls = CLS_TRAP;
          F_MFHI, F_MFLO: begin
            cls   = CLS_MD_MOVE;
            w_src = A3_RD;
          end
          F_MTHI, F_MTLO: cls = CLS_MD_MOVE;
          F_MULT, F_MULTU, F_DIV, F_DIVU: cls = CLS_MD_START;
          default: cls = CLS_UNDEF;
        endcase
      end
      OP_REGIMM: begin
        unique case (w_rt)
          5'h00, 5'h01: cls = CLS_BRANCH;
          5'h10, 5'h11: begin
            cls   = CLS_BRANCH;
            w_src = A3_RA;
          end
          default: cls = CLS_UNDEF;
        endcase
      end
      OP_J:   cls = CLS_JUMP;
      OP_JAL: begin
        cls   = CLS_JUMP;
        w_src = A3_RA;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls   = CLS_ALU_I;
        w_src = A3_RT;
      end
      OP_COP0: begin
        if (w_rs == RS_MF) begin
          cls   = CLS_CP0;
          w_src = A3_RT;
        end else if (w_rs == RS_MT) begin
          cls = CLS_CP0;
        end else if (w_rs == RS_CO && w_fn == F_ERET) begin
          cls = CLS_TRAP;
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls   = CLS_LOAD;
        w_src = A3_RT;
      end
      OP_SB, OP_SH, OP_SW: cls = CLS_STORE;
      default: cls = CLS_UNDEF;
    endcase
  end

  always_comb begin
    a3 = 5'd0;
    unique case (w_src)
      A3_RT:   a3 = w_rt;
      A3_RD:   a3 = w_rd;
      A3_RA:   a3 = 5'd31;
      default: a3 = 5'd0;
    endcase
  end

  assign regwrite = (w_src != A3_ZERO);

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction queue with valid/ready handshakes and a
// multiply/divide busy interlock that holds MD heads while busy.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [3:0]                 out_cls,
  output logic [4:0]                 out_a3,
  output logic                       out_regwrite,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       md_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DIV_CYC + 1);

  dq_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_busy;

  cls_e            w_cls;
  logic [4:0]      w_a3;
  logic            w_rw;
  dq_entry_t       w_head;
  dq_entry_t       w_vis;
  logic            w_empty;
  logic            w_md;
  logic            w_push;
  logic            w_pop;

  instr_classify u_classify (
    .instr    (in_instr),
    .cls      (w_cls),
    .a3       (w_a3),
    .regwrite (w_rw)
  );

  assign w_head  = r_mem[r_rptr];
  assign w_empty = (r_count == '0);
  assign w_md    = (w_head.cls == CLS_MD_START) ||
                   (w_head.cls == CLS_MD_MOVE);
  assign md_busy = (r_busy != '0);

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = !w_empty && !(w_md && md_busy);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_vis        = w_empty ? '0 : w_head;
  assign out_pc       = w_vis.pc;
  assign out_cls      = w_vis.cls;
  assign out_a3       = w_vis.a3;
  assign out_regwrite = w_vis.regwrite;
  assign out_instr    = w_vis.instr;
  assign count        = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{
        pc:       in_pc,
        cls:      w_cls,
        a3:       w_a3,
        regwrite: w_rw,
        instr:    in_instr
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // func bit 1 separates div/divu from mult/multu
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (w_pop && w_head.cls == CLS_MD_START) begin
      r_busy <= w_head.instr[1] ? BW'(DIV_CYC) : BW'(MULT_CYC);
    end else if (r_busy != '0) begin
      r_busy <= r_busy - BW'(1);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: decode vector table, handshake/interlock
// sequences, and randomized traffic against a queue-based model.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_cls;
  logic [4:0]  out_a3;
  logic        out_regwrite;
  logic [31:0] out_instr;
  logic [2:0]  count;
  logic        md_busy;

  decode_queue #(.DEPTH(DEPTH), .MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_cls(out_cls), .out_a3(out_a3),
    .out_regwrite(out_regwrite), .out_instr(out_instr),
    .count(count), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [4:0]  a3;
    logic        rw;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    int          idx;
  } mq_t;

  vec_t tv[$];
  mq_t  mq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] i, input int c,
                     input int a, input logic r);
    vec_t v;
    v.instr = i; v.cls = 4'(c); v.a3 = 5'(a); v.rw = r;
    tv.push_back(v);
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0;
    in_instr = 0; in_pc = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (md_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (md_busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: md_busy stuck");
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic push1(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1; in_instr = i; in_pc = pc;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pop1();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   hidx;
    bit   exp_v, push, pop;
    int   busy;

    add(32'h00221821, 0, 3, 1);   // addu $3,$1,$2
    add(32'h0C000010, 5, 31, 1);  // jal
    add(32'h00000000, 10, 0, 0);  // nop
    add(32'hFC000000, 15, 0, 0);
    add(32'h00062880, 0, 5, 1);   // sll $5,$6,2
    add(32'h8FA80004, 2, 8, 1);   // lw
    add(32'hAFA80004, 3, 0, 0);   // sw
    add(32'h24090005, 1, 9, 1);   // addiu
    add(32'h3C011234, 1, 1, 1);   // lui
    add(32'h10220003, 4, 0, 0);   // beq
    add(32'h04310004, 4, 31, 1);  // bgezal
    add(32'h04200004, 4, 0, 0);   // bltz
    add(32'h08000010, 5, 0, 0);   // j
    add(32'h03E00008, 5, 0, 0);   // jr
    add(32'h0040F809, 5, 31, 1);  // jalr $31,$2
    add(32'h00430018, 6, 0, 0);   // mult
    add(32'h0043001B, 6, 0, 0);   // divu
    add(32'h00002012, 7, 4, 1);   // mflo $4
    add(32'h00800011, 7, 0, 0);   // mthi
    add(32'h40056000, 8, 5, 1);   // mfc0
    add(32'h40856000, 8, 0, 0);   // mtc0
    add(32'h0000000C, 9, 0, 0);   // syscall
    add(32'h42000018, 9, 0, 0);   // eret
    add(32'h00000001, 15, 0, 0);

    rst_n = 0;
    idle_inputs();
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_md_busy", 32'(md_busy), 0);
    chk("rst_out_pc", out_pc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tv.size(); i++) begin
      wait_idle();
      push1(tv[i].instr, 32'h1000 + 32'(i) * 4);
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("tv%0d_cls", i), 32'(out_cls), 32'(tv[i].cls));
      chk($sformatf("tv%0d_a3", i), 32'(out_a3), 32'(tv[i].a3));
      chk($sformatf("tv%0d_rw", i), 32'(out_regwrite), 32'(tv[i].rw));
      chk($sformatf("tv%0d_instr", i), out_instr, tv[i].instr);
      chk($sformatf("tv%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
      chk($sformatf("tv%0d_count", i), 32'(count), 1);
      pop1();
      chk($sformatf("tv%0d_empty_cnt", i), 32'(count), 0);
      chk($sformatf("tv%0d_empty_a3", i), 32'(out_a3), 0);
      chk($sformatf("tv%0d_empty_ins", i), out_instr, 0);
    end

    // full queue: 5th word waits for a pop
    wait_idle();
    in_instr = 32'h00221821;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_pc = 32'h2000 + 32'(k) * 4;
      @(negedge clk);
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    in_pc = 32'h2010;
    @(negedge clk);
    chk("full_held", 32'(count), 4);
    chk("full_head", out_pc, 32'h2000);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_head", out_pc, 32'h2004);
    @(negedge clk);
    in_valid = 0;
    chk("full_refill", 32'(count), 4);
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("order%0d", k), out_pc, 32'h2000 + 32'(k) * 4);
      @(negedge clk);
    end
    out_ready = 0;
    chk("drain_count", 32'(count), 0);

    // mult then mflo: interlock
    wait_idle();
    push1(32'h00430018, 32'h3000);
    push1(32'h00002012, 32'h3004);
    chk("md_head_cls", 32'(out_cls), 6);
    chk("md_head_valid", 32'(out_valid), 1);
    pop1();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("md_busy%0d", k), 32'(md_busy), 1);
      chk($sformatf("md_hold%0d", k), 32'(out_valid), 0);
      chk($sformatf("md_cls%0d", k), 32'(out_cls), 7);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
    chk("md_free", 32'(md_busy), 0);
    chk("md_release", 32'(out_valid), 1);
    chk("md_still_queued", 32'(count), 1);
    pop1();
    chk("md_done", 32'(count), 0);

    // flush with busy countdown running
    wait_idle();
    push1(32'h0043001B, 32'h4000);
    pop1();
    for (int k = 0; k < 3; k++) push1(32'h00221821, 32'h4010 + 32'(k) * 4);
    chk("fl_pre_count", 32'(count), 3);
    flush = 1; in_valid = 1; out_ready = 1;
    in_instr = 32'h00221821; in_pc = 32'hAAAA0000;
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 0;
    chk("fl_count", 32'(count), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_busy", 32'(md_busy), 1);
    chk("fl_pc", out_pc, 0);
    n = 0;
    while (md_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fl_busy_cycles", 32'(n), 6);
    chk("fl_not_enq", 32'(count), 0);

    // asynchronous reset mid-stream
    wait_idle();
    push1(32'h00430018, 32'h5000);
    pop1();
    push1(32'h00221821, 32'h5004);
    push1(32'h00221821, 32'h5008);
    chk("ar_pre_count", 32'(count), 2);
    #2 rst_n = 0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_busy", 32'(md_busy), 0);
    chk("ar_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1;

    // randomized traffic against queue model
    do_reset();
    busy = 0;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 29) == 0);
      hidx      = $urandom_range(0, tv.size() - 1);
      in_instr  = tv[hidx].instr;
      in_pc     = $urandom;
      #1;
      exp_v = 0;
      if (mq.size() > 0) begin
        exp_v = !(busy > 0 && (tv[mq[0].idx].cls == 4'd6 ||
                                tv[mq[0].idx].cls == 4'd7));
      end
      chk("rnd_count", 32'(count), 32'(mq.size()));
      chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_v));
      chk("rnd_md_busy", 32'(md_busy), 32'(busy > 0));
      if (mq.size() > 0) begin
        chk("rnd_pc", out_pc, mq[0].pc);
        chk("rnd_cls", 32'(out_cls), 32'(tv[mq[0].idx].cls));
        chk("rnd_a3", 32'(out_a3), 32'(tv[mq[0].idx].a3));
        chk("rnd_rw", 32'(out_regwrite), 32'(tv[mq[0].idx].rw));
        chk("rnd_instr", out_instr, tv[mq[0].idx].instr);
      end else begin
        chk("rnd_empty_pc", out_pc, 0);
        chk("rnd_empty_cls", 32'(out_cls), 0);
      end
      push = in_valid && (mq.size() < DEPTH);
      pop  = exp_v && out_ready;
      if (flush) begin
        mq.delete();
        if (busy > 0) busy--;
      end else begin
        if (pop && tv[mq[0].idx].cls == 4'd6) begin
          busy = (tv[mq[0].idx].instr[5:0] inside {6'h1A, 6'h1B}) ? 10 : 5;
        end else if (busy > 0) begin
          busy--;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq_t e;
          e.pc = in_pc; e.idx = hidx;
          mq.push_back(e);
        end
      end
      @(negedge clk);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
